// File: rtl/decrypt_engine.sv
// Block decryptor: recovers 32 bytes as C[i]^K[i%8]^i over 32/BYTES_PER_CYCLE RUN cycles
// and checks byte 0 against the XOR of bytes 1..31.
module decrypt_engine #(
  parameter int BYTES_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [255:0] cipher_text,
  input  logic [63:0]  key,
  output logic         busy,
  output logic         done,
  output logic [247:0] plain_text,
  output logic         chk_ok
);

  localparam int B = BYTES_PER_CYCLE;

  if (!(B == 1 || B == 2 || B == 4 || B == 8)) begin : g_bad_param
    $error("decrypt_engine: BYTES_PER_CYCLE must be 1, 2, 4 or 8");
  end

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t         r_state, w_next;
  logic [5:0]     r_cnt;
  logic [255:0]   r_ct;
  logic [63:0]    r_key;
  logic [255:0]   r_pt;
  logic [7:0]     r_xor;

  logic [B-1:0][5:0] w_lidx;
  logic [B-1:0][7:0] w_byte;
  logic [255:0]      w_pt_next;
  logic [7:0]        w_xor_next;
  logic              w_last;
  logic              w_capture;

  // One decrypt lane per byte handled this cycle, lowest index in lane 0.
  for (genvar g = 0; g < B; g++) begin : g_lane
    assign w_lidx[g] = r_cnt + 6'(g);
    assign w_byte[g] = r_ct[{w_lidx[g], 3'b000} +: 8]
                     ^ r_key[{w_lidx[g][2:0], 3'b000} +: 8]
                     ^ {2'b00, w_lidx[g]};
  end

  assign w_last    = (r_state == RUN) && (r_cnt == 6'(32 - B));
  assign w_capture = start && (r_state == IDLE || r_state == DONE);

  always_comb begin
    w_pt_next  = r_pt;
    w_xor_next = r_xor;
    for (int b = 0; b < B; b++) begin
      w_pt_next[{w_lidx[b], 3'b000} +: 8] = w_byte[b];
      w_xor_next = w_xor_next ^ w_byte[b];
    end
  end

  always_comb begin
    w_next = r_state;
    busy   = 1'b0;
    done   = 1'b0;
    case (r_state)
      IDLE: if (start) w_next = RUN;
      RUN: begin
        busy = 1'b1;
        if (w_last) w_next = DONE;
      end
      DONE: begin
        done   = 1'b1;
        w_next = start ? RUN : IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_ct       <= '0;
      r_key      <= '0;
      r_pt       <= '0;
      r_xor      <= '0;
      plain_text <= '0;
      chk_ok     <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_capture) begin
        r_ct  <= cipher_text;
        r_key <= key;
        r_cnt <= '0;
        r_pt  <= '0;
        r_xor <= '0;
      end else if (r_state == RUN) begin
        r_pt  <= w_pt_next;
        r_xor <= w_xor_next;
        r_cnt <= r_cnt + 6'(B);
        // XOR of all 32 bytes is zero exactly when P[0] equals XOR of P[1..31].
        if (w_last) begin
          plain_text <= w_pt_next[255:8];
          chk_ok     <= (w_xor_next == 8'h00);
        end
      end
    end
  end

endmodule

// File: tb/tb_decrypt_engine.sv
// Bench: four engines (1,2,4,8 bytes/cycle) with a per-engine scoreboard of expected
// results and start-to-done latency.
module tb_decrypt_engine;

  logic         clk = 1'b0;
  logic         reset;
  logic [3:0]   start_v;
  logic [255:0] cipher_text;
  logic [63:0]  key;
  logic [3:0]   busy_v, done_v, chk_v;
  logic [247:0] pt_v [4];

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  typedef struct {
    logic [247:0] pt;
    logic         ok;
    int           s;
  } exp_t;

  exp_t sb_q [4][$];
  logic [3:0] prev_done = '0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    decrypt_engine #(.BYTES_PER_CYCLE(1 << g)) u_dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start_v[g]),
      .cipher_text(cipher_text),
      .key        (key),
      .busy       (busy_v[g]),
      .done       (done_v[g]),
      .plain_text (pt_v[g]),
      .chk_ok     (chk_v[g])
    );
  end

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [255:0] ct, input logic [63:0] k, input int s);
    logic [255:0] p;
    logic [7:0]   x;
    exp_t e;
    x = 8'h00;
    for (int i = 0; i < 32; i++) begin
      p[8*i +: 8] = ct[8*i +: 8] ^ k[8*(i%8) +: 8] ^ 8'(i);
      if (i > 0) x = x ^ p[8*i +: 8];
    end
    e.pt = p[255:8];
    e.ok = (p[7:0] == x);
    e.s  = s;
    return e;
  endfunction

  // Latency counts rising edges from the one sampling start through the one raising done.
  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (done_v[i]) begin
        check($sformatf("done_len%0d", i), prev_done[i], 1'b0);
        check($sformatf("busy_in_done%0d", i), busy_v[i], 1'b0);
        if (sb_q[i].size() == 0) begin
          check($sformatf("spurious_done%0d", i), done_v[i], 1'b0);
        end else begin
          exp_t e;
          e = sb_q[i].pop_front();
          check($sformatf("pt%0d", i), pt_v[i], e.pt);
          check($sformatf("chk%0d", i), chk_v[i], e.ok);
          check($sformatf("lat%0d", i), cyc - e.s + 1, 32 / (1 << i) + 1);
        end
      end
      prev_done[i] = done_v[i];
    end
  end

  task automatic go(input logic [3:0] mask, input logic [255:0] ct, input logic [63:0] k);
    cipher_text = ct;
    key         = k;
    start_v     = mask;
    @(posedge clk); #1;
    start_v = '0;
    for (int i = 0; i < 4; i++)
      if (mask[i]) sb_q[i].push_back(model(ct, k, cyc));
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  logic [247:0] zero_pt;
  logic [255:0] rnd;

  initial begin
    reset = 1'b1; start_v = '0; cipher_text = '0; key = '0;
    for (int i = 1; i < 32; i++) zero_pt[8*(i-1) +: 8] = 8'(i);
    idle(2);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("rst_busy%0d", i), busy_v[i], 1'b0);
      check($sformatf("rst_done%0d", i), done_v[i], 1'b0);
      check($sformatf("rst_pt%0d", i), pt_v[i], '0);
      check($sformatf("rst_chk%0d", i), chk_v[i], 1'b0);
    end
    @(negedge clk); reset = 1'b0;
    idle(1);

    // Zero vector, all widths.
    go(4'hF, '0, '0);
    check("busy_run0", busy_v[0], 1'b1);
    idle(40);
    check("zero_pt_const", pt_v[0], zero_pt);
    check("zero_chk_const", chk_v[0], 1'b1);
    check("idle_busy0", busy_v[0], 1'b0);

    // Key 15, all widths.
    go(4'hF, '0, 64'h0F);
    idle(40);
    check("k15_p8", pt_v[0][7*8 +: 8], 8'h07);
    check("k15_p16", pt_v[0][15*8 +: 8], 8'h1F);
    check("k15_p24", pt_v[0][23*8 +: 8], 8'h17);
    check("k15_p9", pt_v[0][8*8 +: 8], 8'h09);
    check("k15_chk", chk_v[0], 1'b1);

    // Corrupted byte 5.
    go(4'hF, 256'h01 << 40, '0);
    idle(40);
    check("corr_p5", pt_v[0][4*8 +: 8], 8'h04);
    check("corr_chk", chk_v[0], 1'b0);

    // Random vectors.
    for (int t = 0; t < 3; t++) begin
      for (int w = 0; w < 8; w++) rnd[32*w +: 32] = $urandom;
      go(4'hF, rnd, {$urandom, $urandom});
      idle(40);
    end

    // Start and input changes during RUN are ignored.
    go(4'h1, {8{32'hA5C3_0F11}}, 64'h0123_4567_89AB_CDEF);
    idle(5);
    start_v = 4'h1; cipher_text = '1; key = '1;
    idle(1);
    start_v = '0;
    idle(40);

    // Back-to-back on the 4-byte engine: start held, garbage inputs during RUN.
    cipher_text = {8{32'h1357_9BDF}}; key = 64'hFEED_FACE_0BAD_F00D;
    start_v = 4'h4;
    @(posedge clk); #1;
    sb_q[2].push_back(model({8{32'h1357_9BDF}}, 64'hFEED_FACE_0BAD_F00D, cyc));
    for (int blk = 0; blk < 3; blk++) begin
      for (int j = 1; j <= 8; j++) begin
        @(posedge clk); #1;
        if (j < 8) begin
          cipher_text = {$urandom, $urandom, $urandom, $urandom,
                         $urandom, $urandom, $urandom, $urandom};
          key = {$urandom, $urandom};
        end else begin
          cipher_text = {8{32'(blk * 32'h1111_1111 + 32'h2468_ACE0)}};
          key = {2{32'(blk + 1)}};
        end
      end
      if (blk == 2) start_v = '0;
      @(posedge clk); #1;
      if (blk < 2) sb_q[2].push_back(model(cipher_text, key, cyc));
    end
    idle(20);

    // Mid-run reset on the 1-byte engine, with start held while reset is high.
    go(4'h1, {8{32'hDEAD_BEEF}}, 64'h55);
    idle(9);
    #2 reset = 1'b1;
    #1;
    check("mrst_busy", busy_v[0], 1'b0);
    check("mrst_done", done_v[0], 1'b0);
    check("mrst_pt", pt_v[0], '0);
    check("mrst_chk", chk_v[0], 1'b0);
    sb_q[0].delete();
    start_v = 4'h1;
    idle(3);
    start_v = '0;
    @(negedge clk); reset = 1'b0;
    idle(3);
    check("post_rst_busy", busy_v[0], 1'b0);
    idle(40);
    go(4'h1, '0, '0);
    idle(40);
    check("post_rst_pt", pt_v[0], zero_pt);

    for (int i = 0; i < 4; i++)
      check($sformatf("sb_empty%0d", i), sb_q[i].size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/decrypt_engine.md
DECRYPT_ENGINE -- requirements
Module: decrypt_engine

Interface
REQ-001 SHALL provide parameter BYTES_PER_CYCLE, default 1, meaning the number of ciphertext bytes processed per RUN cycle (legal values 1, 2, 4 and 8; other values rejected at elaboration).
REQ-002 SHALL provide port clk, input, 1 bit: the single clock; all state changes occur on its rising edge.
REQ-003 SHALL provide port reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL provide port start, input, 1 bit: request to decrypt the current cipher_text/key.
REQ-005 SHALL provide port cipher_text, input, 256 bits: byte i = bits [8i+7:8i], i = 0..31.
REQ-006 SHALL provide port key, input, 64 bits: key byte K[j] = bits [8j+7:8j], j = 0..7.
REQ-007 SHALL provide port busy, output, 1 bit: high while a block is being decrypted.
REQ-008 SHALL provide port done, output, 1 bit: one-cycle completion pulse.
REQ-009 SHALL provide port plain_text, output, 248 bits: recovered plaintext.
REQ-010 SHALL provide port chk_ok, output, 1 bit: high when the embedded checksum matches.

Function
REQ-011 Each plain byte P[i] SHALL equal C[i] XOR K[i mod 8] XOR i[7:0], for i = 0..31.
REQ-012 plain_text SHALL equal {P[31],...,P[1]}, with P[1] in bits [7:0].
REQ-013 chk_ok SHALL be high iff P[0] equals the XOR of P[1] through P[31].
REQ-014 The state machine SHALL have exactly three states: IDLE, RUN and DONE.
REQ-015 IDLE with start high SHALL capture cipher_text and key into internal registers, clear the byte counter and move to RUN.
REQ-016 RUN SHALL process BYTES_PER_CYCLE bytes per cycle, lowest index first, for exactly 32/BYTES_PER_CYCLE cycles, then move to DONE.
REQ-017 On the RUN-to-DONE edge, plain_text and chk_ok SHALL be updated.
- They SHALL then hold until the next RUN-to-DONE edge or reset.
REQ-018 done SHALL be high only in DONE, which lasts one cycle.
- With BYTES_PER_CYCLE = 1, done rises 33 cycles after the edge that sampled start.
REQ-019 DONE SHALL return to IDLE, or go directly to RUN (capturing new inputs) if start is high in DONE.
REQ-020 busy SHALL be high exactly in RUN.
REQ-021 start SHALL be ignored while in RUN.
- Changes to cipher_text/key during RUN SHALL NOT affect the result.
REQ-022 The byte counter SHALL be 6 bits wide, and SHALL NOT wrap or restart inside a block.
REQ-023 All XOR arithmetic SHALL be 8-bit with no carries.
- The index term SHALL be the 8-bit byte index (0x00..0x1F).

Reset
REQ-024 reset high SHALL immediately force IDLE, busy=0, done=0, plain_text=0, chk_ok=0 and counter=0, regardless of clk.
REQ-025 Reset asserted during RUN SHALL abort the block.
- No done pulse SHALL follow for the aborted block.
- After release, the first sampled start SHALL begin a fresh block.
REQ-026 start SHALL be ignored while reset is high.

Verification
REQ-027 Zero vector: cipher_text=0, key=0, start pulse -> after 33 cycles, done=1 for 1 cycle, plain_text={8'h1F,8'h1E,...,8'h01}, chk_ok=1.
REQ-028 Key 15: cipher_text=0, key=64'h0F, start -> P[8]=0x07, P[16]=0x1F, P[24]=0x17, other P[i]=i, P[0]=0x0F, chk_ok=1.
REQ-029 Corruption: zero vector with cipher byte 5 = 0x01 -> plain byte P[5]=0x04, chk_ok=0.
REQ-030 Mid-run reset: start, then reset asserted at cycle 10 of RUN -> outputs 0 at once, no done; a new start then yields the REQ-027 result.
REQ-031 Back-to-back: start held high continuously with BYTES_PER_CYCLE=4 -> done pulses every 9 cycles; start and input changes during RUN have no effect.
REQ-032 Parameter sweep: the REQ-027 and REQ-028 vectors at BYTES_PER_CYCLE = 1, 2, 4, 8 -> identical outputs, with done at 33, 17, 9 and 5 cycles respectively.
